shift_deser: RTL and testbench
==============================

// Module: shift_deser
// PURPOSE
//  Serial-to-parallel receiver; the receive end of the serial link fed by the
//  team's universal shift register (serial bit out of Q end bit).
//  Collects WIDTH bits, MSB-first or LSB-first, into a word and delivers it on a
//  valid/ready port through a one-word holding buffer. Flags framing errors and overruns.
// PARAMETERS
//  WIDTH  4  word width in bits; legal range >= 2
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  clr        in   1      synchronous reset, active-high
//  s_in       in   1      serial data bit
//  s_valid    in   1      s_in valid this cycle; bits taken only when high
//  s_start    in   1      qualifies s_in as first bit of a word (used only with s_valid)
//  dir        in   1      0: MSB-first, 1: LSB-first; sampled with first bit only
//  out_data   out  WIDTH  received word (holding register)
//  out_valid  out  1      holding register full
//  out_ready  in   1      consumer accepts out_data when out_valid & out_ready
//  busy       out  1      word reception in progress (state RECV)
//  frame_err  out  1      one-cycle pulse: word aborted by early s_start
//  overrun    out  1      one-cycle pulse: completed word dropped, buffer full
// BEHAVIOUR
//  - Reset (clr=1 at edge): state IDLE, bit counter 0, shift reg 0, out_data 0,
//    out_valid 0, busy 0, frame_err 0, overrun 0. clr overrides all inputs,
//    including mid-word: partial word discarded, no flags raised.
//  - Bit accept: s_valid=1. s_valid=0 cycles are gaps: state, counter, shift reg hold.
//  - Shift: dir_q=0: sreg <= {sreg[WIDTH-2:0], s_in}; dir_q=1: sreg <= {s_in, sreg[WIDTH-1:1]}.
//  - FSM IDLE: accept with s_start=1 -> load first bit, latch dir_q=dir, cnt=1, -> RECV.
//    Accepted bits with s_start=0 are discarded, no flag. s_start with s_valid=0 ignored.
//  - FSM RECV: accept with s_start=0 -> shift, cnt++. Accept with s_start=1 ->
//    frame_err=1 next cycle, partial word dropped, this bit restarts word
//    (dir re-latched, cnt=1), stay RECV.
//  - Completion: accepted bit with cnt==WIDTH-1 (and s_start=0) -> cnt=0, -> IDLE.
//    Assembled word (including this bit) goes to holding reg if out_valid=0 or
//    out_ready=1 that same cycle; out_data/out_valid=1 visible next cycle (latency 1
//    from last bit). Otherwise word dropped, out_data unchanged, overrun=1 next cycle.
//  - Back-to-back: s_start on the cycle after completion is legal, no gap needed.
//  - Holding reg: out_valid clears on out_valid & out_ready unless reloaded same cycle;
//    out_data stable while out_valid=1 and not consumed.
//  - busy = (state==RECV). frame_err, overrun never high for more than one cycle per event.
//  - Counter width $clog2(WIDTH); no wrap beyond WIDTH-1.
// TESTING (WIDTH=4)
//  1 clr=1 two cycles -> out_valid=0, out_data=0, busy=0, frame_err=0, overrun=0.
//  2 dir=0, bits 1,0,1,1 (start on 1st), out_ready=1 -> next cycle out_data=4'b1011,
//    out_valid=1 for exactly one cycle; busy high during bits 2-4.
//  3 dir=1, bits 1,0,1,1 with s_valid gaps between bits -> out_data=4'b1101, gaps change nothing.
//  4 out_ready=0; send 4'hA then 4'h5 -> overrun pulse after 2nd word, out_data stays 4'hA;
//    repeat with out_ready=1 at 2nd completion -> 4'h5 loaded, no overrun.
//  5 dir=0, bits 1,1 then s_start with bits 0,1,1,0 -> frame_err pulse, out_data=4'b0110.
//  6 clr after 2 bits of a word, then full word 4'h3 -> no output for partial word,
//    out_data=4'h3, no flags.

Source files
------------

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words (MSB- or LSB-first) from a
// serial stream and delivers them through a one-word valid/ready holding buffer.
module shift_deser #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             s_start,
    input  logic             dir,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic             dir_q, dir_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic             valid_nxt, ferr_nxt, ovr_nxt;
    logic [WIDTH-1:0] shifted, first_load;

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            dir_q     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sreg      <= sreg_nxt;
            dir_q     <= dir_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
            busy      <= (state_nxt == RECV);
            frame_err <= ferr_nxt;
            overrun   <= ovr_nxt;
        end
    end

    // First bit lands in an otherwise cleared register so stale bits never leak.
    always_comb begin
        shifted    = dir_q ? {s_in, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], s_in};
        first_load = dir ? {s_in, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, s_in};
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        dir_nxt   = dir_q;
        data_nxt  = out_data;
        valid_nxt = out_valid & ~out_ready;
        ferr_nxt  = 1'b0;
        ovr_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (s_valid && s_start) begin
                    sreg_nxt  = first_load;
                    dir_nxt   = dir;
                    cnt_nxt   = CW'(1);
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (s_valid) begin
                    if (s_start) begin
                        ferr_nxt = 1'b1;
                        sreg_nxt = first_load;
                        dir_nxt  = dir;
                        cnt_nxt  = CW'(1);
                    end else if (cnt == LAST) begin
                        sreg_nxt  = shifted;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                        // Buffer free now or being drained this cycle: take the word.
                        if (!out_valid || out_ready) begin
                            data_nxt  = shifted;
                            valid_nxt = 1'b1;
                        end else begin
                            ovr_nxt = 1'b1;
                        end
                    end else begin
                        sreg_nxt = shifted;
                        cnt_nxt  = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser: a bit-list reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_shift_deser;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         clr, s_in, s_valid, s_start, dir, out_ready;
    logic [W-1:0] out_data;
    logic         out_valid, busy, frame_err, overrun;

    int n_checks = 0;
    int n_pass   = 0;

    shift_deser #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr       (clr),
        .s_in      (s_in),
        .s_valid   (s_valid),
        .s_start   (s_start),
        .dir       (dir),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: keeps the received bits as a list and builds the word arithmetically.
    int m_bits[W];
    int m_n     = 0;
    bit m_inw   = 0;
    bit m_dir   = 0;
    int m_data  = 0;
    bit m_valid = 0;
    bit m_ferr  = 0;
    bit m_ovr   = 0;

    always @(posedge clk) begin
        int  word;
        bit  loaded;
        if (clr) begin
            m_n = 0; m_inw = 0; m_data = 0; m_valid = 0; m_ferr = 0; m_ovr = 0;
        end else begin
            loaded = 0;
            m_ferr = 0;
            m_ovr  = 0;
            if (s_valid) begin
                if (s_start) begin
                    if (m_inw) m_ferr = 1;
                    m_inw = 1; m_dir = dir; m_bits[0] = int'(s_in); m_n = 1;
                end else if (m_inw) begin
                    m_bits[m_n] = int'(s_in);
                    m_n++;
                    if (m_n == W) begin
                        word = 0;
                        for (int i = 0; i < W; i++)
                            word += m_bits[i] * (m_dir ? (1 << i) : (1 << (W - 1 - i)));
                        m_inw = 0; m_n = 0;
                        if (!m_valid || out_ready) begin
                            m_data = word; loaded = 1;
                        end else begin
                            m_ovr = 1;
                        end
                    end
                end
            end
            m_valid = (m_valid && !out_ready) || loaded;
        end
        #1;
        chk("model out_valid", int'(out_valid), int'(m_valid));
        chk("model out_data",  int'(out_data),  m_data);
        chk("model busy",      int'(busy),      int'(m_inw));
        chk("model frame_err", int'(frame_err), int'(m_ferr));
        chk("model overrun",   int'(overrun),   int'(m_ovr));
    end

    task automatic drive(input logic v, input logic st, input logic b, input logic d);
        @(negedge clk);
        s_valid = v; s_start = st; s_in = b; dir = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        clr = 1'b1; s_in = 1'b0; s_valid = 1'b0; s_start = 1'b0; dir = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data",  int'(out_data),  0);
        chk("reset busy",      int'(busy),      0);
        chk("reset frame_err", int'(frame_err), 0);
        chk("reset overrun",   int'(overrun),   0);
        clr = 1'b0;

        // MSB-first 1,0,1,1 -> 4'b1011
        drive(1, 1, 1, 0);
        drive(1, 0, 0, 0);
        chk("t2 busy bit2", int'(busy), 1);
        drive(1, 0, 1, 0);
        drive(1, 0, 1, 0);
        chk("t2 busy bit4", int'(busy), 1);
        idle();
        chk("t2 out_data",  int'(out_data),  4'b1011);
        chk("t2 out_valid", int'(out_valid), 1);
        chk("t2 busy done", int'(busy),      0);
        idle();
        chk("t2 valid one cycle", int'(out_valid), 0);

        // LSB-first 1,0,1,1 with gaps (gap cycles carry junk and s_start) -> 4'b1101
        drive(1, 1, 1, 1);
        drive(0, 1, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 1, 1, 0);
        drive(0, 0, 1, 0);
        drive(1, 0, 1, 0);
        drive(0, 1, 0, 1);
        drive(1, 0, 1, 0);
        idle();
        chk("t3 out_data", int'(out_data), 4'b1101);

        // Overrun: 4'hA held, 4'h5 dropped; then 4'h5 accepted as A drains
        idle();
        out_ready = 1'b0;
        drive(1, 1, 1, 0); drive(1, 0, 0, 0); drive(1, 0, 1, 0); drive(1, 0, 0, 0);
        idle();
        chk("t4 first word", int'(out_data), 4'hA);
        drive(1, 1, 0, 0); drive(1, 0, 1, 0); drive(1, 0, 0, 0); drive(1, 0, 1, 0);
        idle();
        chk("t4 overrun pulse", int'(overrun),   1);
        chk("t4 data kept",     int'(out_data),  4'hA);
        chk("t4 valid kept",    int'(out_valid), 1);
        idle();
        chk("t4 overrun one cycle", int'(overrun), 0);
        drive(1, 1, 0, 0); drive(1, 0, 1, 0); drive(1, 0, 0, 0); drive(1, 0, 1, 0);
        out_ready = 1'b1;
        idle();
        chk("t4 reload data", int'(out_data),  4'h5);
        chk("t4 reload valid", int'(out_valid), 1);
        chk("t4 no overrun",  int'(overrun),   0);

        // Frame error: 1,1 then restart with 0,1,1,0 -> 4'b0110
        drive(1, 1, 1, 0);
        drive(1, 0, 1, 0);
        drive(1, 1, 0, 0);
        drive(1, 0, 1, 0);
        chk("t5 frame_err pulse", int'(frame_err), 1);
        drive(1, 0, 1, 0);
        chk("t5 frame_err one cycle", int'(frame_err), 0);
        drive(1, 0, 0, 0);
        idle();
        chk("t5 out_data", int'(out_data), 4'b0110);

        // Reset mid-word, then 4'h3
        idle();
        drive(1, 1, 0, 0);
        drive(1, 0, 1, 0);
        idle();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t6 busy after clr",  int'(busy),      0);
        chk("t6 valid after clr", int'(out_valid), 0);
        drive(1, 1, 0, 0); drive(1, 0, 0, 0); drive(1, 0, 1, 0); drive(1, 0, 1, 0);
        idle();
        chk("t6 out_data",  int'(out_data),  4'h3);
        chk("t6 out_valid", int'(out_valid), 1);
        chk("t6 frame_err", int'(frame_err), 0);
        chk("t6 overrun",   int'(overrun),   0);

        // Back-to-back words, no gap: MSB 4'h9 then LSB 4'h6 (bits 0,1,1,0)
        drive(1, 1, 1, 0); drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(1, 0, 1, 0);
        drive(1, 1, 0, 1);
        chk("t7 first word", int'(out_data), 4'h9);
        drive(1, 0, 1, 0); drive(1, 0, 1, 0); drive(1, 0, 0, 0);
        idle();
        chk("t7 second word", int'(out_data), 4'h6);

        repeat (3) idle();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
